// File: rtl/mdv_pkg.sv
// Shared definitions for the microdrive controller: control register bit
// positions, drive count limit, FSM state types and a priority helper.
package mdv_pkg;

  localparam int SELCLK     = 0;
  localparam int SELDATA    = 1;
  localparam int RDWR       = 2;
  localparam int ERASE      = 3;
  localparam int MAX_DRIVES = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPIN  = 2'd1,
    S_READY = 2'd2
  } spin_state_e;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_WAIT = 2'd1,
    A_READ = 2'd2
  } arb_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_set(input logic [MAX_DRIVES-1:0] v);
    lowest_set = 3'd0;
    for (int i = MAX_DRIVES - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/mdv_spinup.sv
// Motor spin-up timer: a reloadable down-counter that declares the active
// drive ready SPINUP_CYCLES clocks after it was selected.
//
//   state   | meaning
//   S_IDLE  | no drive selected, counter parked at 0
//   S_SPIN  | motor spinning up, counter running down
//   S_READY | active drive up to speed
module mdv_spinup
  import mdv_pkg::*;
#(
  parameter int SPINUP_CYCLES = 2100000,
  parameter int CNT_W         = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] act_idx,
  input  logic       chain_any,
  output logic       ready
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SPINUP_CYCLES - 1);

  spin_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       act_q;

  // act_idx/chain_any describe the chain as it will be after this edge, so
  // the state moves on the same edge the chain does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      act_q <= '0;
    end else begin
      act_q <= act_idx;
      case (state)
        S_IDLE: begin
          if (chain_any) begin
            state <= S_SPIN;
            cnt   <= RELOAD;
          end
        end
        S_SPIN, S_READY: begin
          if (!chain_any) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (act_idx != act_q) begin
            state <= S_SPIN;
            cnt   <= RELOAD;
          end else if (state == S_SPIN) begin
            if (cnt == '0) state <= S_READY;
            else           cnt   <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign ready = (state == S_READY);

endmodule

// File: rtl/mdv_ctrl.sv
// Microdrive controller: select-chain decode, spin-up tracking and the
// video-idle RAM read slot arbiter. Macro MDV_WRITE_EN enables write/erase.
//
//   state  | meaning
//   A_IDLE | no read outstanding
//   A_WAIT | request latched for drive grant, waiting for an idle slot
//   A_READ | mem_read owned, waiting for the mem_cycle falling edge
module mdv_ctrl
  import mdv_pkg::*;
#(
  parameter int NUM_DRIVES    = 2,
  parameter int SPINUP_CYCLES = 2100000,
  parameter int CNT_W         = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_wr,
  input  logic [3:0]            ctrl_din,
  output logic [NUM_DRIVES-1:0] drv_sel,
  output logic [NUM_DRIVES-1:0] drv_motor,
  output logic                  drv_ready,
  output logic [2:0]            active_drv,
  input  logic [NUM_DRIVES-1:0] drv_req,
  output logic [NUM_DRIVES-1:0] drv_ack,
  input  logic                  mem_ena,
  input  logic                  mem_cycle,
  output logic                  mem_read,
  output logic                  write_mode,
  output logic                  erase
);

  logic [NUM_DRIVES-1:0] chain;
  logic [NUM_DRIVES-1:0] chain_n;
  logic                  last_clk;
  logic                  shift_en;
  logic [2:0]            act_n;
  logic [MAX_DRIVES-1:0] req_ext;

  arb_state_e            arb;
  logic [2:0]            grant;
  logic                  mem_cycle_q;

  // A select-clock high-to-low transition shifts select data into the chain.
  assign shift_en = ctrl_wr && last_clk && !ctrl_din[SELCLK];

  always_comb begin
    chain_n = chain;
    if (shift_en) chain_n = (chain << 1) | NUM_DRIVES'(ctrl_din[SELDATA]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain    <= '0;
      last_clk <= 1'b0;
    end else begin
      chain <= chain_n;
      if (ctrl_wr) last_clk <= ctrl_din[SELCLK];
    end
  end

  assign act_n      = lowest_set(MAX_DRIVES'(chain_n));
  assign active_drv = lowest_set(MAX_DRIVES'(chain));
  assign drv_motor  = chain;

  mdv_spinup #(
    .SPINUP_CYCLES(SPINUP_CYCLES),
    .CNT_W        (CNT_W)
  ) u_spinup (
    .clk      (clk),
    .reset    (reset),
    .act_idx  (act_n),
    .chain_any(|chain_n),
    .ready    (drv_ready)
  );

  assign drv_sel = drv_ready ? (NUM_DRIVES'(1) << active_drv) : '0;
  assign req_ext = MAX_DRIVES'(drv_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb         <= A_IDLE;
      grant       <= '0;
      mem_read    <= 1'b0;
      drv_ack     <= '0;
      mem_cycle_q <= 1'b0;
    end else begin
      mem_cycle_q <= mem_cycle;
      drv_ack     <= '0;
      case (arb)
        A_IDLE: begin
          if (drv_ready && req_ext[active_drv]) begin
            arb   <= A_WAIT;
            grant <= active_drv;
          end
        end
        A_WAIT: begin
          if (!drv_ready) begin
            arb <= A_IDLE;
          end else if (mem_ena && !mem_cycle) begin
            arb      <= A_READ;
            mem_read <= 1'b1;
          end
        end
        A_READ: begin
          // An in-flight read always completes to the latched grant.
          if (mem_cycle_q && !mem_cycle) begin
            drv_ack  <= NUM_DRIVES'(1) << grant;
            mem_read <= 1'b0;
            arb      <= A_IDLE;
          end
        end
        default: begin
          arb      <= A_IDLE;
          mem_read <= 1'b0;
        end
      endcase
    end
  end

`ifdef MDV_WRITE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_mode <= 1'b0;
      erase      <= 1'b0;
    end else if (ctrl_wr) begin
      write_mode <= ctrl_din[RDWR];
      erase      <= ctrl_din[ERASE];
    end
  end
`else
  logic unused_din;
  assign unused_din = ^ctrl_din[ERASE:RDWR];
  assign write_mode = 1'b0;
  assign erase      = 1'b0;
`endif

endmodule

// File: tb/tb_mdv_ctrl.sv
// Self-checking bench for mdv_ctrl: event-level reference model compared
// every cycle, plus directed literal checks on spin-up and slot timing.
module tb_mdv_ctrl;

  localparam int ND   = 2;
  localparam int SPIN = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ctrl_wr = 1'b0;
  logic [3:0]    ctrl_din = 4'h0;
  logic [ND-1:0] drv_sel, drv_motor, drv_ack;
  logic [ND-1:0] drv_req = '0;
  logic          drv_ready, mem_read, write_mode, erase;
  logic [2:0]    active_drv;
  logic          mem_ena = 1'b0;
  logic          mem_cycle = 1'b0;

  int checks = 0;
  int failures = 0;

  mdv_ctrl #(
    .NUM_DRIVES(ND), .SPINUP_CYCLES(SPIN), .CNT_W(22)
  ) dut (
    .clk(clk), .reset(reset), .ctrl_wr(ctrl_wr), .ctrl_din(ctrl_din),
    .drv_sel(drv_sel), .drv_motor(drv_motor), .drv_ready(drv_ready),
    .active_drv(active_drv), .drv_req(drv_req), .drv_ack(drv_ack),
    .mem_ena(mem_ena), .mem_cycle(mem_cycle), .mem_read(mem_read),
    .write_mode(write_mode), .erase(erase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: chain contents, time of last (re)selection, and one
  // outstanding slot transaction.
  int m_chain = 0, m_start = 0, e_n = 0, m_grant = 0, m_ack = 0;
  bit m_last = 0, m_pend = 0, m_reading = 0, m_prev_cyc = 0, m_wm = 0, m_er = 0;
  int r_act, r_nc, r_req;
  bit r_rdy;

  function automatic int lowest(input int v);
    for (int i = 0; i < 8; i++) if (((v >> i) & 1) != 0) return i;
    return 0;
  endfunction

  function automatic bit m_ready(input int now);
    return (m_chain != 0) && ((now - m_start) >= SPIN);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_chain = 0; m_start = 0; e_n = 0; m_grant = 0; m_ack = 0;
      m_last = 0; m_pend = 0; m_reading = 0; m_prev_cyc = 0; m_wm = 0; m_er = 0;
    end else begin
      r_rdy = m_ready(e_n);
      r_act = lowest(m_chain);
      r_req = int'(drv_req);
      m_ack = 0;
      if (m_reading) begin
        if (m_prev_cyc && !mem_cycle) begin
          m_ack = 1 << m_grant;
          m_reading = 0;
        end
      end else if (m_pend) begin
        if (!r_rdy) m_pend = 0;
        else if (mem_ena && !mem_cycle) begin
          m_pend = 0;
          m_reading = 1;
        end
      end else if (r_rdy && ((r_req >> r_act) & 1) != 0) begin
        m_pend = 1;
        m_grant = r_act;
      end
      e_n++;
      if (ctrl_wr) begin
        if (m_last && !ctrl_din[0]) begin
          r_nc = ((m_chain << 1) | int'(ctrl_din[1])) & ((1 << ND) - 1);
          if (r_nc != 0 && (m_chain == 0 || lowest(r_nc) != r_act)) m_start = e_n;
          m_chain = r_nc;
        end
        m_last = ctrl_din[0];
`ifdef MDV_WRITE_EN
        m_wm = ctrl_din[2];
        m_er = ctrl_din[3];
`endif
      end
      m_prev_cyc = mem_cycle;
    end
  end

  logic [12:0] c_exp, c_got;
  bit          c_rdy;
  int          c_act;
  always @(negedge clk) begin
    c_rdy = m_ready(e_n);
    c_act = lowest(m_chain);
    c_exp = {2'(m_chain), (c_rdy ? 2'(1 << c_act) : 2'b00), c_rdy, 3'(c_act),
             m_reading, 2'(m_ack), m_wm, m_er};
    c_got = {drv_motor, drv_sel, drv_ready, active_drv, mem_read, drv_ack, write_mode, erase};
    chk("model_cycle", 32'(c_got), 32'(c_exp));
  end

  task automatic wr(input logic [3:0] d);
    @(negedge clk);
    ctrl_wr = 1'b1;
    ctrl_din = d;
    @(negedge clk);
    ctrl_wr = 1'b0;
  endtask

  int cnt;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'({drv_motor, drv_sel, drv_ready, mem_read, drv_ack, active_drv}), 0);

    // Select drive 0 and time its spin-up.
    wr(4'h1);
    wr(4'h2);
    chk("chain_01", 32'(drv_motor), 32'h1);
    cnt = drv_ready ? 1 : 0;
    repeat (9) begin
      @(negedge clk);
      if (drv_ready || drv_sel != 0) cnt++;
    end
    chk("ready_early", cnt, 0);
    @(negedge clk);
    chk("ready_at_10", 32'(drv_ready), 1);
    chk("sel_drive0", 32'(drv_sel), 32'h1);

    // Request with the slot held closed, then one full read.
    drv_req = 2'b01;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (mem_read) cnt++;
    end
    chk("no_read_without_ena", cnt, 0);
    mem_ena = 1'b1;
    @(negedge clk);
    chk("mem_read_rise", 32'(mem_read), 1);
    mem_ena = 1'b0;
    mem_cycle = 1'b1;
    repeat (2) @(negedge clk);
    chk("mem_read_held", 32'(mem_read), 1);
    mem_cycle = 1'b0;
    @(negedge clk);
    chk("ack_drive0", 32'(drv_ack), 32'h1);
    chk("mem_read_drop", 32'(mem_read), 0);
    mem_ena = 1'b1;
    @(negedge clk);
    chk("ack_one_clk", 32'(drv_ack), 0);
    @(negedge clk);
    chk("held_req_reread", 32'(mem_read), 1);
    mem_ena = 1'b0;

    // Reset in the middle of a read.
    #2 reset = 1'b1;
    #1 chk("reset_midread", 32'({mem_read, drv_sel, drv_ack, drv_motor}), 0);
    drv_req = 2'b00;
    @(negedge clk);
    #2 reset = 1'b0;

    // Requests from a non-active drive are ignored.
    wr(4'h1);
    wr(4'h2);
    repeat (12) @(negedge clk);
    drv_req = 2'b10;
    mem_ena = 1'b1;
    mem_cycle = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_read) cnt++;
    end
    chk("inactive_req_ignored", cnt, 0);
    drv_req = 2'b00;
    mem_ena = 1'b0;

    // Shift a zero: drive 1 becomes active, spin-up restarts.
    wr(4'h1);
    wr(4'h0);
    chk("chain_10", 32'(drv_motor), 32'h2);
    chk("active_1", 32'(active_drv), 1);
    cnt = (drv_ready || drv_sel != 0) ? 1 : 0;
    repeat (9) begin
      @(negedge clk);
      if (drv_ready || drv_sel != 0) cnt++;
    end
    chk("restart_no_sel", cnt, 0);
    @(negedge clk);
    chk("sel_drive1", 32'(drv_sel), 32'h2);

    // Another zero empties the chain.
    wr(4'h1);
    wr(4'h0);
    chk("chain_empty_idle", 32'({drv_motor, drv_ready, drv_sel}), 0);

    wr(4'hC);
`ifdef MDV_WRITE_EN
    chk("write_erase", 32'({write_mode, erase}), 32'h3);
`else
    chk("write_erase", 32'({write_mode, erase}), 32'h0);
`endif
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
